data_bus_unit: RTL and testbench

- Downstream data-bus stage for the accumulator controller.
- Consumes the controller's 95-bit output vector (bus request plus debug fields) and returns the 32-bit busIn word one cycle later.
- Contains a word RAM, a TX FIFO stream port, an RX holding register, a free-running cycle counter and a halt latch.
- The controller never stalls, so every access completes with a fixed latency.

---
 rtl/data_bus_unit_if.sv | 31 +++
 rtl/data_bus_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_data_bus_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_unit_if.sv
// data_bus_unit_if
//   Bundle of the bus-side signals of data_bus_unit.
//   slave  : the data-bus unit (consumes ctrlOut, drives busIn and streams).
//   master : the surrounding controller / stream endpoints.
//   Signals:
//     ctrlOut  [94:0]  controller output vector (request + debug fields)
//     busIn    [31:0]  read data returned to the controller
//     tx_valid/tx_data/tx_ready  TX stream (unit -> sink)
//     rx_valid/rx_data/rx_ready  RX stream (source -> unit)
//     halted           sticky exit indication
interface data_bus_unit_if;
  logic [94:0] ctrlOut;
  logic [31:0] busIn;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic        halted;

  modport master (
    output ctrlOut, tx_ready, rx_valid, rx_data,
    input  busIn, tx_valid, tx_data, rx_ready, halted
  );

  modport slave (
    input  ctrlOut, tx_ready, rx_valid, rx_data,
    output busIn, tx_valid, tx_data, rx_ready, halted
  );
endinterface

// File: rtl/data_bus_unit.sv
// data_bus_unit
//   Downstream data-bus stage of the accumulator controller. Decodes the
//   controller's output vector and serves every access with a fixed one-cycle
//   read latency: word RAM, TX FIFO push port, status, RX holding register and
//   a free-running cycle counter. A sticky halt latch captures the exit bit.
//   Ports:
//     CLK    clock, all state updates on posedge
//     RESET  synchronous, active-high reset
//     bus    data_bus_unit_if.slave (ctrlOut, busIn, TX/RX streams, halted)
//   Address map:
//     0x00..RAM_WORDS-1  RAM
//     0xF0  TX push (reads 0)
//     0xF1  STATUS {23'b0, overflow, rx_full, tx_full, tx_empty, count[4:0]};
//           any write clears overflow
//     0xF2  RX pop (reads 0 when empty)
//     0xF3  CYCLE counter (read only)
module data_bus_unit #(
  parameter int RAM_WORDS = 240,
  parameter int TX_DEPTH  = 4
) (
  input logic           CLK,
  input logic           RESET,
  data_bus_unit_if.slave bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int TX_AW  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int TX_CW  = TX_AW + 1;

  localparam logic [8:0]       RAM_LIMIT   = 9'(RAM_WORDS);
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

  localparam logic [7:0] ADDR_TX   = 8'hF0;
  localparam logic [7:0] ADDR_STAT = 8'hF1;
  localparam logic [7:0] ADDR_RX   = 8'hF2;
  localparam logic [7:0] ADDR_CYC  = 8'hF3;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [7:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic        exit_req;
  logic [51:0] unused_fields;   // acc, pc and instr debug fields

  assign addr          = bus.ctrlOut[94:87];
  assign rd            = bus.ctrlOut[86];
  assign wr            = bus.ctrlOut[85];
  assign wdata         = bus.ctrlOut[84:53];
  assign unused_fields = bus.ctrlOut[52:1];
  assign exit_req      = bus.ctrlOut[0];

  logic ram_sel;
  logic tx_sel;
  logic stat_sel;
  logic rx_sel;

  assign ram_sel  = ({1'b0, addr} < RAM_LIMIT);
  assign tx_sel   = (addr == ADDR_TX);
  assign stat_sel = (addr == ADDR_STAT);
  assign rx_sel   = (addr == ADDR_RX);

  // ---------------------------------------------------------------------------
  // Word RAM (contents are not reset)
  // ---------------------------------------------------------------------------
  logic [31:0]       ram_mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx = addr[RAM_AW-1:0];

  always_ff @(posedge CLK) begin
    if (wr && ram_sel) begin
      ram_mem[ram_idx] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      fifo_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d;
  logic [TX_AW-1:0] tx_rptr_q, tx_rptr_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             ovf_q, ovf_d;

  logic tx_empty;
  logic tx_full;
  logic tx_pop;
  logic tx_push_req;
  logic tx_push;

  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == TX_FULL_CNT);
  assign tx_pop      = !tx_empty && bus.tx_ready;
  assign tx_push_req = wr && tx_sel;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds when the head is leaving.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    ovf_d     = ovf_q;

    if (tx_push) begin
      tx_wptr_d = tx_wptr_q + TX_AW'(1);
    end
    if (tx_pop) begin
      tx_rptr_d = tx_rptr_q + TX_AW'(1);
    end

    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase

    if (wr && stat_sel) begin
      ovf_d = 1'b0;
    end else if (tx_push_req && !tx_push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_push) begin
      fifo_mem[tx_wptr_q] <= wdata;
    end
  end

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = fifo_mem[tx_rptr_q];

  // ---------------------------------------------------------------------------
  // RX holding register
  // ---------------------------------------------------------------------------
  logic        rx_full_q, rx_full_d;
  logic [31:0] rx_hold_q, rx_hold_d;
  logic        rx_capture;
  logic        rx_take;

  assign rx_capture = bus.rx_valid && !rx_full_q;
  assign rx_take    = rd && rx_sel;

  // Capture wins over a same-cycle read: the read returns the old (empty)
  // contents and the register ends up full with the new word.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    if (rx_capture) begin
      rx_full_d = 1'b1;
      rx_hold_d = bus.rx_data;
    end else if (rx_take) begin
      rx_full_d = 1'b0;
    end
  end

  assign bus.rx_ready = !rx_full_q;

  // ---------------------------------------------------------------------------
  // Cycle counter and halt latch
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_q, cycle_d;
  logic        halted_q, halted_d;

  assign cycle_d  = halted_q ? cycle_q : cycle_q + 32'd1;
  assign halted_d = halted_q | exit_req;

  assign bus.halted = halted_q;

  // ---------------------------------------------------------------------------
  // Read mux and busIn register
  // ---------------------------------------------------------------------------
  logic [4:0]  tx_cnt5;
  logic [31:0] status_word;
  logic [31:0] rd_data;
  logic [31:0] busin_q, busin_d;

  assign tx_cnt5     = 5'(tx_cnt_q);
  assign status_word = {23'b0, ovf_q, rx_full_q, tx_full, tx_empty, tx_cnt5};

  // RAM is read before this edge's write lands, so rd+wr to one address
  // returns the pre-write word.
  always_comb begin
    rd_data = '0;
    if (ram_sel) begin
      rd_data = ram_mem[ram_idx];
    end else begin
      case (addr)
        ADDR_STAT: rd_data = status_word;
        ADDR_RX:   rd_data = rx_full_q ? rx_hold_q : 32'd0;
        ADDR_CYC:  rd_data = cycle_q;
        default:   rd_data = '0;
      endcase
    end
  end

  assign busin_d   = rd ? rd_data : busin_q;
  assign bus.busIn = busin_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busin_q   <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
      cycle_q   <= '0;
      halted_q  <= 1'b0;
    end else begin
      busin_q   <= busin_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
      cycle_q   <= cycle_d;
      halted_q  <= halted_d;
    end
  end

endmodule

// File: tb/tb_data_bus_unit.sv
// tb_data_bus_unit
//   Directed bench for data_bus_unit: RAM, TX FIFO with overflow, RX holding
//   register, halt latch, cycle counter and mid-operation reset.
module tb_data_bus_unit;

  logic clk;
  logic reset;

  data_bus_unit_if bus_if ();

  data_bus_unit #(
    .RAM_WORDS (240),
    .TX_DEPTH  (4)
  ) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [51:0] JUNK = 52'h5A5A5A5A5A5A5;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cyc_model = '0;
  logic        halt_model = 1'b0;
  logic [31:0] exp_cyc;

  task automatic drive(input logic [7:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic e);
    bus_if.ctrlOut = {a, r, w, d, JUNK, e};
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    if (reset) begin
      cyc_model  = '0;
      halt_model = 1'b0;
    end else begin
      if (!halt_model) cyc_model = cyc_model + 32'd1;
      if (bus_if.ctrlOut[0]) halt_model = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus_if.tx_ready = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 32'h0;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_busIn", bus_if.busIn, 32'h0);
    check("rst_halted", {31'b0, bus_if.halted}, 32'h0);
    check("rst_tx_valid", {31'b0, bus_if.tx_valid}, 32'h0);
    check("rst_rx_ready", {31'b0, bus_if.rx_ready}, 32'h1);

    // Cycle counter restarts at 0 after reset
    reset = 1'b0;
    drive(8'hF3, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("cyc_first", bus_if.busIn, 32'h0);
    tick();
    check("cyc_second", bus_if.busIn, 32'h1);

    drive(8'hF1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("status_reset", bus_if.busIn, 32'h0000_0020);

    // RAM write / read, hold, unmapped and boundary
    drive(8'h05, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    idle();
    tick();
    drive(8'h05, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("ram_rd_05", bus_if.busIn, 32'hDEADBEEF);
    idle();
    tick();
    check("busIn_hold", bus_if.busIn, 32'hDEADBEEF);
    drive(8'hF7, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("rd_unmapped", bus_if.busIn, 32'h0);
    drive(8'hEF, 1'b0, 1'b1, 32'hCAFE0001, 1'b0);
    tick();
    drive(8'hEF, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("ram_rd_last", bus_if.busIn, 32'hCAFE0001);
    drive(8'hF0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("rd_tx_zero", bus_if.busIn, 32'h0);
    drive(8'h05, 1'b1, 1'b1, 32'h11111111, 1'b0);
    tick();
    check("rdwr_prewrite", bus_if.busIn, 32'hDEADBEEF);
    drive(8'h05, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("rdwr_committed", bus_if.busIn, 32'h11111111);

    // TX overflow: five pushes into a depth-4 FIFO with the sink stalled
    bus_if.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(8'hF0, 1'b0, 1'b1, 32'(i), 1'b0);
      tick();
    end
    check("tx_valid_full", {31'b0, bus_if.tx_valid}, 32'h1);
    check("tx_head_stable", bus_if.tx_data, 32'h1);
    drive(8'hF1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("status_ovf", bus_if.busIn, 32'h0000_0144);
    drive(8'hF1, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    drive(8'hF1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("status_ovf_clr", bus_if.busIn, 32'h0000_0044);
    idle();
    bus_if.tx_ready = 1'b1;
    check("tx_drain_1", bus_if.tx_data, 32'h1);
    tick();
    check("tx_drain_2", bus_if.tx_data, 32'h2);
    tick();
    check("tx_drain_3", bus_if.tx_data, 32'h3);
    tick();
    check("tx_drain_4", bus_if.tx_data, 32'h4);
    tick();
    check("tx_empty_after", {31'b0, bus_if.tx_valid}, 32'h0);

    // Push and pop together while full
    bus_if.tx_ready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      drive(8'hF0, 1'b0, 1'b1, 32'(i), 1'b0);
      tick();
    end
    bus_if.tx_ready = 1'b1;
    drive(8'hF0, 1'b0, 1'b1, 32'd14, 1'b0);
    tick();
    bus_if.tx_ready = 1'b0;
    drive(8'hF1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("status_pushpop", bus_if.busIn, 32'h0000_0044);
    idle();
    bus_if.tx_ready = 1'b1;
    check("pp_head_11", bus_if.tx_data, 32'd11);
    tick();
    check("pp_head_12", bus_if.tx_data, 32'd12);
    tick();
    check("pp_head_13", bus_if.tx_data, 32'd13);
    tick();
    check("pp_head_14", bus_if.tx_data, 32'd14);
    tick();
    check("pp_empty", {31'b0, bus_if.tx_valid}, 32'h0);
    bus_if.tx_ready = 1'b0;

    // RX holding register
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 32'h1234;
    tick();
    check("rx_ready_drop", {31'b0, bus_if.rx_ready}, 32'h0);
    bus_if.rx_data = 32'h5678;
    tick();
    bus_if.rx_valid = 1'b0;
    drive(8'hF1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("status_rx_full", bus_if.busIn, 32'h0000_00A0);
    drive(8'hF2, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("rx_read", bus_if.busIn, 32'h1234);
    check("rx_ready_back", {31'b0, bus_if.rx_ready}, 32'h1);
    tick();
    check("rx_read_empty", bus_if.busIn, 32'h0);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 32'hBEEF;
    tick();
    check("rx_rd_cap_old", bus_if.busIn, 32'h0);
    check("rx_rd_cap_full", {31'b0, bus_if.rx_ready}, 32'h0);
    bus_if.rx_valid = 1'b0;
    tick();
    check("rx_rd_cap_new", bus_if.busIn, 32'hBEEF);

    // Halt
    idle();
    tick();
    check("pre_halt", {31'b0, bus_if.halted}, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("halted_set", {31'b0, bus_if.halted}, 32'h1);
    exp_cyc = cyc_model;
    drive(8'hF3, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("cyc_frozen_1", bus_if.busIn, exp_cyc);
    tick();
    check("cyc_frozen_2", bus_if.busIn, exp_cyc);
    drive(8'h05, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("ram_after_halt", bus_if.busIn, 32'h11111111);
    check("halted_sticky", {31'b0, bus_if.halted}, 32'h1);

    // Reset mid-operation
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'hF0, 1'b0, 1'b1, 32'h21 + 32'(i), 1'b0);
      tick();
    end
    idle();
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 32'h77;
    tick();
    bus_if.rx_valid = 1'b0;
    check("pre_rst_tx", {31'b0, bus_if.tx_valid}, 32'h1);
    check("pre_rst_rx", {31'b0, bus_if.rx_ready}, 32'h0);
    reset = 1'b1;
    drive(8'h05, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("mrst_busIn", bus_if.busIn, 32'h0);
    check("mrst_tx_valid", {31'b0, bus_if.tx_valid}, 32'h0);
    check("mrst_rx_ready", {31'b0, bus_if.rx_ready}, 32'h1);
    check("mrst_halted", {31'b0, bus_if.halted}, 32'h0);
    reset = 1'b0;
    drive(8'hF3, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("mrst_cyc_0", bus_if.busIn, 32'h0);
    tick();
    check("mrst_cyc_1", bus_if.busIn, 32'h1);
    drive(8'hF1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("mrst_status", bus_if.busIn, 32'h0000_0020);

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
